// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide engine for the EX stage.
// Stalls the front of the pipeline while iterating and returns one registered result.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  rd_q, rd_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic [2:0]  f3;
  logic        accept, sa_in, sb_in, div_zero, div_ovf, fast;
  logic [31:0] mag_a, mag_b, fast_res;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_sub;
  logic [63:0] acc_step, mul_full;
  logic [31:0] div_val, div_res, final_res;

  assign f3     = funct_i[2:0];
  assign accept = (state_q == IDLE) && req_i && (funct_i[9:3] == 7'b0000001) && !rst_i;

  // Operand signedness: DIV/REM are signed on both sides, MULHSU only on rs1.
  assign sa_in = rs1_data_i[31] & (f3[2] ? ~f3[0] : ((f3 == 3'b001) || (f3 == 3'b010)));
  assign sb_in = rs2_data_i[31] & (f3[2] ? ~f3[0] : (f3 == 3'b001));
  assign mag_a = sa_in ? -rs1_data_i : rs1_data_i;
  assign mag_b = sb_in ? -rs2_data_i : rs2_data_i;

  assign div_zero = f3[2] && (rs2_data_i == 32'd0);
  assign div_ovf  = f3[2] && !f3[0] && (rs1_data_i == 32'h8000_0000) &&
                    (rs2_data_i == 32'hFFFF_FFFF);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (f3[1] ? rs1_data_i : 32'hFFFF_FFFF)
                             : (f3[1] ? 32'd0 : 32'h8000_0000);

  // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_sub   = div_shift[31:0] - b_q;
  assign acc_step  = op_q[2] ?
                     ((div_shift >= {1'b0, b_q}) ? {div_sub, acc_q[30:0], 1'b1}
                                                 : {div_shift[31:0], acc_q[30:0], 1'b0})
                   : {mul_sum, acc_q[31:1]};

  assign mul_full  = neg_q ? (64'd0 - acc_step) : acc_step;
  assign div_val   = op_q[1] ? acc_step[63:32] : acc_step[31:0];
  assign div_res   = neg_q ? -div_val : div_val;
  assign final_res = op_q[2] ? div_res : ((op_q == 3'b000) ? mul_full[31:0] : mul_full[63:32]);

  assign stall_o   = accept || (state_q == BUSY);
  assign done_o    = done_q;
  assign result_o  = res_q;
  assign rd_addr_o = rd_out_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    res_d    = res_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = f3;
          rd_d  = rd_addr_i;
          neg_d = (f3[2] && f3[1]) ? sa_in : (sa_in ^ sb_in);
          b_d   = f3[2] ? mag_b : mag_a;
          acc_d = {32'd0, (f3[2] ? mag_a : mag_b)};
          if (fast) begin
            state_d  = DONE;
            cnt_d    = 6'd0;
            done_d   = 1'b1;
            res_d    = fast_res;
            rd_out_d = rd_addr_i;
          end else begin
            state_d = BUSY;
            cnt_d   = 6'd32;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d  = DONE;
          done_d   = 1'b1;
          res_d    = final_res;
          rd_out_d = rd_q;
        end
      end
      // req_i still shows the finishing instruction here, so it is ignored.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      rd_q     <= 5'd0;
      done_q   <= 1'b0;
      res_q    <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      res_q    <= res_d;
      rd_out_q <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, timing, reset abort,
// back-to-back issue and random ops against a reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [9:0]  funct;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .funct_i(funct),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .rd_addr_i(rd_addr),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drives an op in the current cycle and records its expected outcome.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
    req = 1'b1; funct = {7'b0000001, f}; rs1_data = a; rs2_data = b; rd_addr = rd;
    exp_q.push_back(exp_res);
    exp_rd_q.push_back(rd);
  endtask

  // Counts cycles from the issue cycle to done_o; operands are scrambled after accept.
  task automatic wait_done(output int lat, output int stalls);
    int k;
    lat = -1; stalls = 0; k = 0;
    while (lat < 0 && k < 100) begin
      @(negedge clk);
      if (done_o) lat = k;
      else begin
        if (stall_o) stalls++;
        @(posedge clk); #1;
        if (k == 0) begin rs1_data = $urandom; rs2_data = $urandom; end
        k++;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b want=0", done_o); end
    tests_run++; if (result_o !== 32'd0) begin tests_failed++; $display("FAIL reset_result got=%h want=0", result_o); end
    tests_run++; if (rd_addr_o !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got=%0d want=0", rd_addr_o); end
  endtask

  task automatic test_mul_timing;
    int lat, stalls;
    logic [31:0] e; logic [4:0] er;
    @(posedge clk); #1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    wait_done(lat, stalls);
    e = exp_q.pop_front(); er = exp_rd_q.pop_front();
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL mul_latency got=%0d want=33", lat); end
    tests_run++; if (stalls !== 33) begin tests_failed++; $display("FAIL mul_stall_cycles got=%0d want=33", stalls); end
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL mul_stall_in_done got=%b want=0", stall_o); end
    tests_run++; if (result_o !== e) begin tests_failed++; $display("FAIL mul_result got=%h want=%h", result_o, e); end
    tests_run++; if (rd_addr_o !== er) begin tests_failed++; $display("FAIL mul_rd got=%0d want=%0d", rd_addr_o, er); end
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL mul_done_one_cycle got=%b want=0", done_o); end
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL mul_no_reissue got=%b want=0", stall_o); end
  endtask

  task automatic test_directed;
    logic [2:0]  t_f[11]   = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] t_a[11]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] t_b[11]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_r[11]   = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int          t_l[11]   = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    int lat, stalls;
    logic [31:0] e; logic [4:0] er;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      issue(t_f[i], t_a[i], t_b[i], 5'(i + 8), t_r[i]);
      wait_done(lat, stalls);
      e = exp_q.pop_front(); er = exp_rd_q.pop_front();
      tests_run++; if (lat !== t_l[i]) begin tests_failed++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_l[i]); end
      tests_run++; if (result_o !== e) begin tests_failed++; $display("FAIL dir%0d_result got=%h want=%h", i, result_o, e); end
      tests_run++; if (rd_addr_o !== er) begin tests_failed++; $display("FAIL dir%0d_rd got=%0d want=%0d", i, rd_addr_o, er); end
      @(posedge clk); #1; req = 1'b0;
    end
  endtask

  task automatic test_reset_abort;
    int seen = 0;
    @(posedge clk); #1;
    req = 1'b1; funct = {7'b0000001, 3'd4}; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd9;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    rst = 1'b1; req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL abort_stall got=%b want=0", stall_o); end
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b want=0", done_o); end
    tests_run++; if (result_o !== 32'd0) begin tests_failed++; $display("FAIL abort_result got=%h want=0", result_o); end
    tests_run++; if (rd_addr_o !== 5'd0) begin tests_failed++; $display("FAIL abort_rd got=%0d want=0", rd_addr_o); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done_o) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, stalls;
    logic [31:0] e; logic [4:0] er;
    @(posedge clk); #1;
    issue(3'd0, 32'd123, 32'd456, 5'd3, 32'd56088);
    wait_done(lat1, stalls);
    e = exp_q.pop_front(); er = exp_rd_q.pop_front();
    tests_run++; if (result_o !== e) begin tests_failed++; $display("FAIL b2b_first_result got=%h want=%h", result_o, e); end
    @(posedge clk); #1;
    issue(3'd0, 32'hFFFF_FFFF, 32'd10, 5'd4, 32'hFFFF_FFF6);
    wait_done(lat2, stalls);
    e = exp_q.pop_front(); er = exp_rd_q.pop_front();
    tests_run++; if (lat1 + 1 + lat2 !== 67) begin tests_failed++; $display("FAIL b2b_second_done_cycle got=%0d want=67", lat1 + 1 + lat2); end
    tests_run++; if (result_o !== e) begin tests_failed++; $display("FAIL b2b_second_result got=%h want=%h", result_o, e); end
    tests_run++; if (rd_addr_o !== er) begin tests_failed++; $display("FAIL b2b_second_rd got=%0d want=%0d", rd_addr_o, er); end
    @(posedge clk); #1; req = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [2:0] f; logic [31:0] a, b, e; logic [4:0] er;
    int lat, stalls, el;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      el = exp_lat(f, a, b);
      @(posedge clk); #1;
      issue(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
      wait_done(lat, stalls);
      e = exp_q.pop_front(); er = exp_rd_q.pop_front();
      tests_run++; if (lat !== el) begin tests_failed++; $display("FAIL rnd%0d_latency f=%0d got=%0d want=%0d", i, f, lat, el); end
      tests_run++; if (result_o !== e) begin tests_failed++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h want=%h", i, f, a, b, result_o, e); end
      tests_run++; if (rd_addr_o !== er) begin tests_failed++; $display("FAIL rnd%0d_rd got=%0d want=%0d", i, rd_addr_o, er); end
      @(posedge clk); #1; req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; funct = 10'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_mul_timing;
    test_directed;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide engine in the EX stage. It consumes the instruction the ID/EX pipeline register presents to EX: funct, both register operands and rd. While it runs it holds the front of the pipeline with a stall, then hands back a 32-bit result for EX/MEM to capture. Radix-2: one bit per cycle, 32 iterations per operation, with a fast path for divide special cases.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  reset, synchronous, active-high.
- req_i  input  1  the instruction currently held by ID/EX is an M-extension op (opcode 0110011, funct7 0000001).
- funct_i  input  10  {funct7, funct3} from ID/EX.
- rs1_data_i  input  32  operand A (forwarded value).
- rs2_data_i  input  32  operand B (forwarded value).
- rd_addr_i  input  5  destination register.
- stall_o  output  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- done_o  output  1  result_o and rd_addr_o are valid this cycle.
- result_o  output  32  final result.
- rd_addr_o  output  5  captured rd for the completed op.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- IDLE:
  - If req_i=1 and funct_i[9:3]=0000001: latch the operands, funct3 and rd, then go to BUSY.
  - Divide special cases go directly to DONE instead (see the fast path below).
  - Otherwise stay in IDLE.
- BUSY: one iteration per cycle, driven by a 6-bit counter loaded with 32. At the edge where the counter reaches 0, go to DONE.
- DONE: done_o=1 for exactly one cycle, then return to IDLE. req_i is ignored in DONE because it still reflects the same instruction.
- funct3 encoding and result:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed×unsigned.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Signed ops work on operand magnitudes and record the result sign:
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Negation is 2's complement, applied when entering DONE.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring divide with a 32-bit remainder and a 33-bit subtract.
- Fast path, IDLE→DONE in one cycle:
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = rs1.
  - Signed overflow, rs1=0x80000000 with rs2=0xFFFFFFFF on DIV/REM: quotient = 0x80000000, remainder = 0.
- Multiply never takes the fast path; operand value does not change latency.
- stall_o = (IDLE and accept) or BUSY. It is 0 in DONE, so ID/EX advances at the end of the DONE cycle.
- Reset while BUSY or DONE: abort, return to IDLE, and zero all outputs on the next edge. No result is produced.

## Timing
- Reset values: stall_o=0, done_o=0, result_o=0, rd_addr_o=0. The state is IDLE and the counter is 0.
- Normal op, with accept in cycle T (req_i=1 in IDLE):
  - stall_o=1 in T through T+32, which is 33 stall cycles.
  - done_o=1 in T+33.
- Fast-path op: stall_o=1 in T only; done_o=1 in T+1.
- result_o and rd_addr_o are registered. They hold their last value until the next DONE; consumers qualify them with done_o.
- Back-to-back ops: the next instruction reaches ID/EX at the end of the DONE cycle. It is accepted in the following IDLE cycle, so there is exactly one IDLE cycle between consecutive ops.
- Operands are sampled only at accept. Changes on rs*_data_i during BUSY are ignored.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3), accept at T:
  - stall_o high in T..T+32.
  - done_o in T+33 with result_o=0xFFFFFFEB and rd_addr_o = the issued rd.
- MULHU, 0xFFFFFFFF×0xFFFFFFFF: result 0xFFFFFFFE.
- MULH, same operands: result 0x00000000.
- MULHSU, rs1=0xFFFFFFFF, rs2=2: result 0xFFFFFFFF.
- DIV −7/2: result 0xFFFFFFFD.
- REM −7/2: result 0xFFFFFFFF.
- DIVU 100/7: result 14.
- REMU 100/7: result 2.
- DIVU 5/0: done_o in T+1, result 0xFFFFFFFF.
- REM 5/0: result 5.
- DIV 0x80000000/0xFFFFFFFF: result 0x80000000 at T+1.
- Assert rst_i at T+10 during a DIV:
  - At T+11: stall_o=0, done_o=0, result_o=0.
  - No done_o follows.
- Two MULs back-to-back, req_i held high across the DONE cycle:
  - The second op is accepted at T+34 and finishes at T+67.
  - The stale req_i in DONE does not cause a re-issue.
